// File: rtl/life_stepper_pkg.sv
// Shared types and helpers for the Game of Life next-generation engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } life_step_t;

    function automatic int unsigned cell_idx(input int unsigned x, input int unsigned y,
                                             input int unsigned width);
        return y * width + x;
    endfunction

    // B3/S23: birth on exactly three neighbours, survival on two or three.
    function automatic logic next_cell(input logic alive, input logic [3:0] n);
        return (n == 4'd3) || (alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_stepper_if.sv
// Board/handshake bundle between the board register side and the stepper.
interface life_stepper_if #(
    parameter int unsigned map_width  = 8,
    parameter int unsigned map_height = 8
);
    localparam int unsigned Cells = map_width * map_height;
    localparam int unsigned PopW  = $clog2(Cells + 1);

    logic             start;
    logic [Cells-1:0] state_cur;
    logic [Cells-1:0] state_next;
    logic             busy;
    logic             done;
    logic [PopW-1:0]  population;
    logic [15:0]      generation;

    modport master (
        output start, state_cur,
        input  state_next, busy, done, population, generation
    );

    modport slave (
        input  start, state_cur,
        output state_next, busy, done, population, generation
    );

endinterface

// File: rtl/life_row_eval.sv
// Combinational B3/S23 evaluation of one row from its two vertical neighbour rows.
module life_row_eval
    import life_pkg::*;
#(
    parameter int unsigned map_width = 8
) (
    input  logic [map_width-1:0] above_i,
    input  logic [map_width-1:0] cur_i,
    input  logic [map_width-1:0] below_i,
    input  logic                 wrap_i,
    output logic [map_width-1:0] row_o
);
    localparam int unsigned XW = $clog2(map_width);

    logic [3:0]    n;
    int            xi;
    logic          in_range;
    logic [XW-1:0] xs;

    always_comb begin
        row_o    = '0;
        n        = '0;
        xi       = 0;
        in_range = 1'b0;
        xs       = '0;
        for (int x = 0; x < int'(map_width); x++) begin
            n = '0;
            for (int dx = -1; dx <= 1; dx++) begin
                xi       = x + dx;
                in_range = 1'b1;
                // Columns past either edge wrap around or read as dead.
                if (xi < 0) begin
                    xi       = int'(map_width) - 1;
                    in_range = wrap_i;
                end else if (xi >= int'(map_width)) begin
                    xi       = 0;
                    in_range = wrap_i;
                end
                xs = XW'(xi);
                if (in_range) begin
                    n = n + {3'b000, above_i[xs]} + {3'b000, below_i[xs]};
                    if (dx != 0) n = n + {3'b000, cur_i[xs]};
                end
            end
            row_o[x] = next_cell(cur_i[x], n);
        end
    end

endmodule

// File: rtl/life_stepper.sv
// Row-serial next-generation engine: snapshot, evaluate one row per clock, commit atomically.
module life_stepper
    import life_pkg::*;
#(
    parameter int unsigned map_width  = 8,
    parameter int unsigned map_height = 8,
    parameter bit          wrap       = 1'b1
) (
    input logic           clock,
    input logic           reset,
    life_stepper_if.slave bus
);
    localparam int unsigned Cells = map_width * map_height;
    localparam int unsigned PopW  = $clog2(Cells + 1);
    localparam int unsigned RowW  = $clog2(map_height);
    localparam logic [RowW-1:0] LastRow = RowW'(map_height - 1);

    life_step_t       state_q, state_d;
    logic [Cells-1:0] snap_q, snap_d, work_q, work_d, state_next_q, state_next_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [PopW-1:0]  pop_q, pop_d, work_pop;
    logic [15:0]      gen_q, gen_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [map_width-1:0] row_above, row_cur, row_below, row_new;

    // Pick snap rows row-1, row, row+1; rows off the board read as dead without wrap.
    always_comb begin
        row_above = '0;
        row_cur   = '0;
        row_below = '0;
        for (int unsigned r = 0; r < map_height; r++) begin
            if (RowW'(r) == row_q) row_cur = snap_q[cell_idx(0, r, map_width) +: map_width];
            if ((RowW'((r + 1) % map_height) == row_q) && (wrap || (r + 1 < map_height)))
                row_above = snap_q[cell_idx(0, r, map_width) +: map_width];
            if ((RowW'((r + map_height - 1) % map_height) == row_q) && (wrap || (r > 0)))
                row_below = snap_q[cell_idx(0, r, map_width) +: map_width];
        end
    end

    life_row_eval #(
        .map_width(map_width)
    ) u_row_eval (
        .above_i(row_above),
        .cur_i  (row_cur),
        .below_i(row_below),
        .wrap_i (wrap),
        .row_o  (row_new)
    );

    always_comb begin
        work_pop = '0;
        for (int unsigned i = 0; i < Cells; i++) work_pop = work_pop + PopW'(work_q[i]);
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        work_d       = work_q;
        row_d        = row_q;
        state_next_d = state_next_q;
        pop_d        = pop_q;
        gen_d        = gen_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d  = bus.state_cur;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                for (int unsigned r = 0; r < map_height; r++) begin
                    if (RowW'(r) == row_q) work_d[cell_idx(0, r, map_width) +: map_width] = row_new;
                end
                if (row_q == LastRow) begin
                    row_d   = '0;
                    state_d = COMMIT;
                end else begin
                    row_d = row_q + RowW'(1);
                end
            end
            COMMIT: begin
                state_next_d = work_q;
                pop_d        = work_pop;
                gen_d        = gen_q + 16'd1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            work_q       <= '0;
            row_q        <= '0;
            state_next_q <= '0;
            pop_q        <= '0;
            gen_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            work_q       <= work_d;
            row_q        <= row_d;
            state_next_q <= state_next_d;
            pop_q        <= pop_d;
            gen_q        <= gen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.state_next = state_next_q;
    assign bus.population = pop_q;
    assign bus.generation = gen_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_life_stepper.sv
// Directed bench for life_stepper: one toroidal and one bounded instance on a shared clock.
module tb_life_stepper;
    import life_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    life_stepper_if #(.map_width(W), .map_height(H)) bw ();
    life_stepper_if #(.map_width(W), .map_height(H)) bn ();

    life_stepper #(.map_width(W), .map_height(H), .wrap(1'b1)) dut_w (
        .clock(clock),
        .reset(reset),
        .bus  (bw)
    );

    life_stepper #(.map_width(W), .map_height(H), .wrap(1'b0)) dut_n (
        .clock(clock),
        .reset(reset),
        .bus  (bn)
    );

    logic [63:0] horiz, vert, block, col0, wrap_res, nowrap_res, g0, g4;

    task automatic do_reset();
        reset = 1'b0;
        bw.start = 1'b0;
        bn.start = 1'b0;
        bw.state_cur = '0;
        bn.state_cur = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Pulse start on one instance; lat = edges from accept until done is seen, -1 on timeout.
    task automatic run_step(input bit w, output int lat);
        @(negedge clock);
        if (w) bw.start = 1'b1;
        else bn.start = 1'b1;
        @(posedge clock);
        #1;
        bw.start = 1'b0;
        bn.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if ((w && bw.done) || (!w && bn.done)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bw.state_next !== 64'd0) begin failures++;
            $display("FAIL reset_state_next got=%h exp=0", bw.state_next); end
        checks++; if (bw.population !== 7'd0) begin failures++;
            $display("FAIL reset_population got=%0d exp=0", bw.population); end
        checks++; if (bw.generation !== 16'd0) begin failures++;
            $display("FAIL reset_generation got=%0d exp=0", bw.generation); end
        checks++; if (bw.busy !== 1'b0 || bw.done !== 1'b0) begin failures++;
            $display("FAIL reset_busy_done got=%b%b exp=00", bw.busy, bw.done); end
        checks++; if (bn.state_next !== 64'd0 || bn.generation !== 16'd0) begin failures++;
            $display("FAIL reset_nowrap got=%h/%0d exp=0/0", bn.state_next, bn.generation); end
    endtask

    task automatic test_blinker();
        int lat;
        do_reset();
        bn.state_cur = horiz;
        run_step(1'b0, lat);
        checks++; if (lat !== 9) begin failures++;
            $display("FAIL blinker_latency got=%0d exp=9", lat); end
        checks++; if (bn.state_next !== vert) begin failures++;
            $display("FAIL blinker_vert got=%h exp=%h", bn.state_next, vert); end
        checks++; if (bn.population !== 7'd3) begin failures++;
            $display("FAIL blinker_pop got=%0d exp=3", bn.population); end
        checks++; if (bn.generation !== 16'd1) begin failures++;
            $display("FAIL blinker_gen got=%0d exp=1", bn.generation); end
        bn.state_cur = vert;
        run_step(1'b0, lat);
        checks++; if (bn.state_next !== horiz) begin failures++;
            $display("FAIL blinker_horiz got=%h exp=%h", bn.state_next, horiz); end
        checks++; if (bn.generation !== 16'd2) begin failures++;
            $display("FAIL blinker_gen2 got=%0d exp=2", bn.generation); end
    endtask

    task automatic test_still_life();
        int lat;
        do_reset();
        bn.state_cur = block;
        for (int s = 1; s <= 5; s++) begin
            run_step(1'b0, lat);
            checks++; if (bn.state_next !== block || bn.population !== 7'd4) begin failures++;
                $display("FAIL still_step%0d got=%h/%0d exp=%h/4", s, bn.state_next,
                         bn.population, block); end
        end
        checks++; if (bn.generation !== 16'd5) begin failures++;
            $display("FAIL still_gen got=%0d exp=5", bn.generation); end
    endtask

    task automatic test_edge_wrap();
        int lat;
        do_reset();
        bw.state_cur = col0;
        bn.state_cur = col0;
        run_step(1'b1, lat);
        checks++; if (bw.state_next !== wrap_res || bw.population !== 7'd3) begin failures++;
            $display("FAIL edge_wrap got=%h/%0d exp=%h/3", bw.state_next, bw.population,
                     wrap_res); end
        run_step(1'b0, lat);
        checks++; if (bn.state_next !== nowrap_res || bn.population !== 7'd2) begin failures++;
            $display("FAIL edge_nowrap got=%h/%0d exp=%h/2", bn.state_next, bn.population,
                     nowrap_res); end
    endtask

    task automatic test_glider();
        int lat;
        do_reset();
        bw.state_cur = g0;
        for (int s = 1; s <= 32; s++) begin
            run_step(1'b1, lat);
            checks++; if (lat !== 9 || bw.population !== 7'd5) begin failures++;
                $display("FAIL glider_step%0d lat=%0d pop=%0d exp=9/5", s, lat, bw.population); end
            if (s == 4) begin
                checks++; if (bw.state_next !== g4) begin failures++;
                    $display("FAIL glider_phase4 got=%h exp=%h", bw.state_next, g4); end
            end
            bw.state_cur = bw.state_next;
        end
        checks++; if (bw.state_next !== g0) begin failures++;
            $display("FAIL glider_final got=%h exp=%h", bw.state_next, g0); end
        checks++; if (bw.generation !== 16'd32) begin failures++;
            $display("FAIL glider_gen got=%0d exp=32", bw.generation); end
    endtask

    task automatic test_busy();
        int          dt[3];
        logic [63:0] ds[3];
        logic [15:0] dg[3];
        int          nd;
        do_reset();
        bw.state_cur = horiz;
        nd = 0;
        for (int j = 0; j < 3; j++) begin
            dt[j] = -1;
            ds[j] = 'x;
            dg[j] = 'x;
        end
        @(negedge clock);
        bw.start = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clock);
            #1;
            if (i == 4) bw.state_cur = '0;
            if (i == 5) begin
                checks++; if (bw.busy !== 1'b1) begin failures++;
                    $display("FAIL busy_mid got=%b exp=1", bw.busy); end
            end
            if (i == 10) begin
                checks++; if (bw.busy !== 1'b0) begin failures++;
                    $display("FAIL busy_commit got=%b exp=0", bw.busy); end
            end
            if (i == 30) bw.start = 1'b0;
            if (bw.done) begin
                if (nd < 3) begin
                    dt[nd] = i;
                    ds[nd] = bw.state_next;
                    dg[nd] = bw.generation;
                end
                nd++;
            end
        end
        checks++; if (nd !== 3) begin failures++;
            $display("FAIL busy_commits got=%0d exp=3", nd); end
        checks++; if (dt[0] !== 10 || dt[1] !== 20 || dt[2] !== 30) begin failures++;
            $display("FAIL busy_spacing got=%0d,%0d,%0d exp=10,20,30", dt[0], dt[1], dt[2]); end
        checks++; if (ds[0] !== vert) begin failures++;
            $display("FAIL busy_snapshot got=%h exp=%h", ds[0], vert); end
        checks++; if (ds[1] !== 64'd0 || dg[2] !== 16'd3) begin failures++;
            $display("FAIL busy_later got=%h/%0d exp=0/3", ds[1], dg[2]); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        do_reset();
        bw.state_cur = horiz;
        run_step(1'b1, lat);
        @(negedge clock);
        bw.start = 1'b1;
        @(posedge clock);
        #1;
        bw.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bw.state_next !== 64'd0 || bw.population !== 7'd0) begin failures++;
            $display("FAIL midreset_board got=%h/%0d exp=0/0", bw.state_next, bw.population); end
        checks++; if (bw.generation !== 16'd0 || bw.busy !== 1'b0 || bw.done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ctrl gen=%0d busy=%b done=%b exp=0/0/0", bw.generation,
                     bw.busy, bw.done); end
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (bw.done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++;
            $display("FAIL midreset_no_done got=%b exp=0", seen); end
        run_step(1'b1, lat);
        checks++; if (lat !== 9 || bw.generation !== 16'd1 || bw.state_next !== vert) begin
            failures++;
            $display("FAIL midreset_restart lat=%0d gen=%0d got=%h exp=9/1/%h", lat,
                     bw.generation, bw.state_next, vert); end
    endtask

    initial begin
        horiz = '0; horiz[cell_idx(2, 3, W)] = 1'b1; horiz[cell_idx(3, 3, W)] = 1'b1;
        horiz[cell_idx(4, 3, W)] = 1'b1;
        vert = '0; vert[cell_idx(3, 2, W)] = 1'b1; vert[cell_idx(3, 3, W)] = 1'b1;
        vert[cell_idx(3, 4, W)] = 1'b1;
        block = '0; block[cell_idx(0, 0, W)] = 1'b1; block[cell_idx(1, 0, W)] = 1'b1;
        block[cell_idx(0, 1, W)] = 1'b1; block[cell_idx(1, 1, W)] = 1'b1;
        col0 = '0; col0[cell_idx(0, 3, W)] = 1'b1; col0[cell_idx(0, 4, W)] = 1'b1;
        col0[cell_idx(0, 5, W)] = 1'b1;
        nowrap_res = '0; nowrap_res[cell_idx(0, 4, W)] = 1'b1;
        nowrap_res[cell_idx(1, 4, W)] = 1'b1;
        wrap_res = nowrap_res; wrap_res[cell_idx(7, 4, W)] = 1'b1;
        g0 = '0; g0[cell_idx(1, 0, W)] = 1'b1; g0[cell_idx(2, 1, W)] = 1'b1;
        g0[cell_idx(0, 2, W)] = 1'b1; g0[cell_idx(1, 2, W)] = 1'b1; g0[cell_idx(2, 2, W)] = 1'b1;
        g4 = '0; g4[cell_idx(2, 1, W)] = 1'b1; g4[cell_idx(3, 2, W)] = 1'b1;
        g4[cell_idx(1, 3, W)] = 1'b1; g4[cell_idx(2, 3, W)] = 1'b1; g4[cell_idx(3, 3, W)] = 1'b1;

        test_reset();
        test_blinker();
        test_still_life();
        test_edge_wrap();
        test_glider();
        test_busy();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_stepper.md
# life_stepper

Next-generation engine for the Game of Life datapath. It samples the current board, evaluates Conway's B3/S23 rule row-serially at one row per clock, and presents the complete next board plus its population as one atomic update. It sits directly upstream of the board state register: its `state_next` drives that register's next-state input, and its `done` pulse drives that register's enable.

## Interface

Parameters:

- `map_width`, default 8: cells per row; must be ≥ 3.
- `map_height`, default 8: rows; must be ≥ 3.
- `wrap`, default 1: 1 = toroidal edges; 0 = cells outside the board count as dead.

Ports:

- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request one generation step; sampled only in IDLE.
- `state_cur` input `map_width*map_height`: current board; cell (x,y) is bit `y*map_width+x`.
- `state_next` output `map_width*map_height`: registered next board, same bit mapping.
- `busy` output 1: high from the accepting edge until commit.
- `done` output 1: single-cycle pulse; `state_next` is valid and new.
- `population` output `$clog2(map_width*map_height+1)`: live-cell count of `state_next`.
- `generation` output 16: count of commits since reset; wraps at 65535 → 0.

## Operation

- FSM states are IDLE, COMPUTE and COMMIT.
- IDLE with `start`=1:
  - snapshot `state_cur` into an internal `snap` register; `state_cur` is not read again until the next start;
  - clear row counter `row` to 0;
  - go to COMPUTE.
- COMPUTE, each edge:
  - compute next-state bits for row `row` from `snap` rows `row-1`, `row`, `row+1`;
  - write that row into the `work` buffer;
  - increment `row`;
  - after `row` = `map_height-1`, go to COMMIT.
- Neighbour indexing:
  - `wrap`=1: row and column indices are taken modulo width/height.
  - `wrap`=0: out-of-range neighbours read as 0.
- Rule per cell: n = live-neighbour count (0..8).
  - Dead cell becomes live iff n = 3.
  - Live cell stays live iff n = 2 or 3.
- COMMIT, one edge:
  - `state_next` ← `work`;
  - `population` ← popcount(`work`);
  - `generation` ← `generation`+1, modulo 2^16;
  - `done` ← 1;
  - go to IDLE.
- `start` is ignored in COMPUTE and COMMIT; there is no queuing.
- `start` is accepted in the cycle where `done` is high, because the FSM is then in IDLE.
- `state_next`, `population` and `generation` hold their values between commits.
- Reset (`reset`=0, asynchronous):
  - FSM → IDLE, `row`=0, `busy`=0, `done`=0;
  - `state_next`=0, `population`=0, `generation`=0;
  - `snap` and `work` are cleared to 0.
  - Reset mid-COMPUTE aborts the step: no commit, and no `done`.

## Timing

- Start accepted at edge k. `busy` is high from edge k until edge k+H+1 (H = `map_height`).
- Rows 0..H-1 are written at edges k+1..k+H.
- Commit happens at edge k+H+1: `state_next`, `population`, `generation` and `done` all update at that edge, and `busy` falls at the same edge.
- `done` is high for exactly one cycle, after edge k+H+1.
- Start-to-result latency is H+1 clocks. Back-to-back throughput is one generation per H+2 clocks (IDLE cycle included).
- Every output is registered; none has a combinational path from an input.

## Structure

- Shared package `life_pkg`:
  - function `cell_idx(x, y, width)`;
  - function `next_cell(alive, n)` implementing B3/S23;
  - FSM state enum `life_step_t` {IDLE, COMPUTE, COMMIT}.
- Sub-module `life_row_eval`, combinational:
  - inputs: three `map_width`-bit rows (above, current, below) plus `wrap`;
  - output: the `map_width`-bit next row;
  - instantiated once and time-multiplexed over `row`.
- Popcount is an adder tree in `life_stepper`, evaluated on `work` at COMMIT.

## Test plan

- **Blinker.** 8×8, `wrap`=0. Cells (2,3),(3,3),(4,3) live; pulse `start`.
  - `done` arrives exactly 9 clocks later.
  - `state_next` has (3,2),(3,3),(3,4) live; `population`=3; `generation`=1.
  - A second step restores the horizontal pattern.
- **Still life.** 2×2 block at (0,0)..(1,1), `wrap`=0, 5 steps.
  - `state_next` is unchanged every step; `population`=4; `generation`=5.
- **Edge wrap.** Vertical blinker on column 0, rows 3..5.
  - `wrap`=1: result has live cells (7,4),(0,4),(1,4), population 3.
  - `wrap`=0: result has (0,4),(1,4), population 2.
- **Glider on torus.** 8×8 torus, glider, 32 consecutive steps.
  - Final board equals the initial board; `population`=5 after every step; `generation`=32.
- **Busy handling.** Hold `start` high continuously.
  - Commits occur every 10 clocks.
  - `start` pulses during `busy` produce no extra commits.
  - Changing `state_cur` mid-COMPUTE does not alter the result.
- **Reset mid-step.** Assert `reset` low at edge k+4.
  - All outputs read 0 immediately, asynchronously.
  - No `done` follows.
  - A fresh `start` after release completes normally with `generation`=1.
